// File: rtl/alu_sequencer.sv
// Command sequencer wrapped around an external combinational 4-bit ALU.
// Accepts one command at a time, steps it through IDLE/EXEC/RESP and holds an accumulator.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic       cmd_load,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_acc,
    output logic       rsp_zero,
    output logic       rsp_carry,
    output logic       carry_sticky,
    output logic [7:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] acc;
    logic [3:0] b_reg;
    logic [2:0] op_reg;
    logic       load_reg;
    logic       accept;

    logic [3:0] next_acc;
    logic       next_zero;
    logic       next_carry;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;

    assign alu_a  = acc;
    assign alu_b  = b_reg;
    assign alu_op = op_reg;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A load bypasses the ALU entirely; its flags are derived locally.
    always_comb begin
        if (load_reg) begin
            next_acc   = b_reg;
            next_zero  = (b_reg == 4'd0);
            next_carry = 1'b0;
        end else begin
            next_acc   = alu_result;
            next_zero  = alu_zero;
            next_carry = alu_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= 4'd0;
            b_reg        <= 4'd0;
            op_reg       <= 3'd0;
            load_reg     <= 1'b0;
            rsp_acc      <= 4'd0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            carry_sticky <= 1'b0;
            op_count     <= 8'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_reg   <= cmd_op;
                b_reg    <= cmd_data;
                load_reg <= cmd_load;
            end
            if (state == EXEC) begin
                acc       <= next_acc;
                rsp_acc   <= next_acc;
                rsp_zero  <= next_zero;
                rsp_carry <= next_carry;
                if (load_reg) begin
                    carry_sticky <= 1'b0;
                end else begin
                    carry_sticky <= carry_sticky | alu_carry;
                    op_count     <= op_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written corner
// sequences, and randomized commands checked against an arithmetic reference model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       cmd_load;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       carry_sticky;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_acc;
    int m_zero;
    int m_carry;
    int m_sticky;
    int m_count;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_load(cmd_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_acc(rsp_acc), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .carry_sticky(carry_sticky), .op_count(op_count)
    );

    // Plain-arithmetic ALU: returns {carry, result}. SUB carry is the borrow.
    function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai, bi, r, c;
        ai = int'(a);
        bi = int'(b);
        c  = 0;
        case (op)
            3'd0: begin r = (ai + bi) % 16; c = (ai + bi > 15) ? 1 : 0; end
            3'd1: begin r = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0; end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = (ai * (1 << bi)) % 16;
            3'd6: r = ai / (1 << bi);
            default: r = 15 - int'(a | b);
        endcase
        return {c[0], r[3:0]};
    endfunction

    always_comb begin
        logic [4:0] res;
        res        = ref_alu(alu_op, alu_a, alu_b);
        alu_result = res[3:0];
        alu_carry  = res[4];
        alu_zero   = (res[3:0] == 4'd0);
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic       load;
        int         acc;
        int         zero;
        int         carry;
        int         sticky;
        int         count;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one command through accept/EXEC/RESP and checks every phase.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] data, input logic load,
                                 input int bp, input bit idle_ready, input bit pulse,
                                 input int e_acc, input int e_zero, input int e_carry,
                                 input int e_sticky, input int e_count);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_load  = load;
        rsp_ready = idle_ready;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 4'($urandom);
        cmd_load  = 1'($urandom);
        checkOutput("exec_cmd_ready", int'(cmd_ready), 0);
        checkOutput("exec_rsp_valid", int'(rsp_valid), 0);
        if (!load) begin
            checkOutput("exec_alu_b", int'(alu_b), int'(data));
            checkOutput("exec_alu_op", int'(alu_op), int'(op));
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("rsp_valid", int'(rsp_valid), 1);
        checkOutput("rsp_acc", int'(rsp_acc), e_acc);
        checkOutput("rsp_zero", int'(rsp_zero), e_zero);
        checkOutput("rsp_carry", int'(rsp_carry), e_carry);
        checkOutput("carry_sticky", int'(carry_sticky), e_sticky);
        checkOutput("op_count", int'(op_count), e_count);
        checkOutput("resp_alu_a", int'(alu_a), e_acc);
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            if (pulse && k == 1) begin
                cmd_valid = 1'b1;
                cmd_load  = 1'b0;
                cmd_op    = 3'd0;
                cmd_data  = 4'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_rsp_valid", int'(rsp_valid), 1);
            checkOutput("bp_cmd_ready", int'(cmd_ready), 0);
            checkOutput("bp_rsp_acc", int'(rsp_acc), e_acc);
            checkOutput("bp_rsp_zero", int'(rsp_zero), e_zero);
            checkOutput("bp_rsp_carry", int'(rsp_carry), e_carry);
            checkOutput("bp_op_count", int'(op_count), e_count);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("done_rsp_valid", int'(rsp_valid), 0);
        checkOutput("done_cmd_ready", int'(cmd_ready), 1);
    endtask

    task automatic modelStep(input logic [2:0] op, input logic [3:0] data, input logic load,
                             input int bp, input bit idle_ready);
        logic [4:0] res;
        if (load) begin
            m_acc    = int'(data);
            m_zero   = (data == 4'd0) ? 1 : 0;
            m_carry  = 0;
            m_sticky = 0;
        end else begin
            res      = ref_alu(op, 4'(m_acc), data);
            m_acc    = int'(res[3:0]);
            m_zero   = (res[3:0] == 4'd0) ? 1 : 0;
            m_carry  = int'(res[4]);
            m_sticky = m_sticky | m_carry;
            m_count  = (m_count + 1) % 256;
        end
        applyStimulus(op, data, load, bp, idle_ready, 1'b0, m_acc, m_zero, m_carry, m_sticky, m_count);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_rsp_acc"}, int'(rsp_acc), 0);
        checkOutput({tag, "_rsp_zero"}, int'(rsp_zero), 0);
        checkOutput({tag, "_rsp_carry"}, int'(rsp_carry), 0);
        checkOutput({tag, "_sticky"}, int'(carry_sticky), 0);
        checkOutput({tag, "_op_count"}, int'(op_count), 0);
        checkOutput({tag, "_alu_a"}, int'(alu_a), 0);
        checkOutput({tag, "_alu_b"}, int'(alu_b), 0);
        checkOutput({tag, "_alu_op"}, int'(alu_op), 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        cmd_load  = 1'b0;
        rsp_ready = 1'b0;

        vecs[0]  = '{3'd0, 4'd5, 1'b1,  5, 0, 0, 0,  0};
        vecs[1]  = '{3'd0, 4'd3, 1'b0,  8, 0, 0, 0,  1};
        vecs[2]  = '{3'd0, 4'd9, 1'b0,  1, 0, 1, 1,  2};
        vecs[3]  = '{3'd2, 4'd0, 1'b0,  0, 1, 0, 1,  3};
        vecs[4]  = '{3'd0, 4'd1, 1'b1,  1, 0, 0, 0,  3};
        vecs[5]  = '{3'd1, 4'd1, 1'b0,  0, 1, 0, 0,  4};
        vecs[6]  = '{3'd1, 4'd1, 1'b0, 15, 0, 1, 1,  5};
        vecs[7]  = '{3'd4, 4'd6, 1'b0,  9, 0, 0, 1,  6};
        vecs[8]  = '{3'd3, 4'd0, 1'b0,  9, 0, 0, 1,  7};
        vecs[9]  = '{3'd5, 4'd1, 1'b0,  2, 0, 0, 1,  8};
        vecs[10] = '{3'd6, 4'd1, 1'b0,  1, 0, 0, 1,  9};
        vecs[11] = '{3'd7, 4'd1, 1'b0, 14, 0, 0, 1, 10};
        vecs[12] = '{3'd0, 4'd0, 1'b1,  0, 1, 0, 0, 10};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].data, vecs[i].load, 0, 1'b0, 1'b0,
                          vecs[i].acc, vecs[i].zero, vecs[i].carry, vecs[i].sticky, vecs[i].count);
        end
        m_acc = 0; m_zero = 1; m_carry = 0; m_sticky = 0; m_count = 10;

        // Backpressure for 4 cycles with a stray command pulse in the middle.
        m_acc = 2; m_zero = 0; m_carry = 0; m_count = 11;
        applyStimulus(3'd0, 4'd2, 1'b0, 4, 1'b0, 1'b1, m_acc, m_zero, m_carry, m_sticky, m_count);
        checkOutput("bp_count_after", int'(op_count), 11);

        // Reset during EXEC of ADD 7.
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'd7; cmd_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("rst_exec_in_exec", int'(cmd_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState("rst_exec");
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_exec_no_rsp", int'(rsp_valid), 0);
        end
        rsp_ready = 1'b0;

        // Reset while a response is pending.
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'd9; cmd_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_pending", int'(rsp_valid), 1);
        checkOutput("rst_resp_acc_pre", int'(rsp_acc), 9);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState("rst_resp");
        m_acc = 0; m_zero = 0; m_carry = 0; m_sticky = 0; m_count = 0;

        // 256 random non-load commands: op_count must wrap back to zero.
        for (int i = 0; i < 256; i++) begin
            modelStep(3'($urandom), 4'($urandom), 1'b0, int'($urandom_range(0, 2)), 1'($urandom));
        end
        checkOutput("wrap_op_count", int'(op_count), 0);
        modelStep(3'd0, 4'($urandom), 1'b1, 0, 1'b0);
        checkOutput("wrap_load_count", int'(op_count), 0);
        checkOutput("wrap_load_sticky", int'(carry_sticky), 0);

        // Mixed random commands including loads.
        for (int i = 0; i < 60; i++) begin
            modelStep(3'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
